// File: rtl/cache_port_arbiter_pkg.sv
// Shared types for the cache port arbiter: FSM state encoding and address/word defaults.
package cachepkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    WAIT    = 2'd2,
    RESPOND = 2'd3
  } arb_state_t;

  localparam int unsigned DEF_ADDRBITS = 32;
  localparam int unsigned DEF_WORDBITS = 32;

  typedef logic [DEF_ADDRBITS-1:0] addr_t;
  typedef logic [DEF_WORDBITS-1:0] word_t;

  // Index width that stays at least one bit for degenerate port counts.
  function automatic int unsigned idx_bits(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/cache_port_arbiter_rr_picker.sv
// Combinational round-robin picker: first requester at or after ptr, optionally
// restricted to a priority subset when any member of that subset is requesting.
module rr_picker
  import cachepkg::*;
#(
  parameter  int unsigned REQUESTERS = 2,
  localparam int unsigned IW         = idx_bits(REQUESTERS)
) (
  input  logic [REQUESTERS-1:0] req,
  input  logic [IW-1:0]         ptr,
  input  logic [REQUESTERS-1:0] prio_mask,
  output logic [IW-1:0]         winner,
  output logic                  any_valid
);

  logic [REQUESTERS-1:0] prio_req;
  logic [REQUESTERS-1:0] cand;
  logic                  found;
  int                    idx;

  always_comb begin
    prio_req  = req & prio_mask;
    cand      = (|prio_req) ? prio_req : req;
    any_valid = |req;
    winner    = '0;
    found     = 1'b0;
    idx       = 0;
    for (int k = 0; k < int'(REQUESTERS); k++) begin
      idx = int'(ptr) + k;
      if (idx >= int'(REQUESTERS)) idx = idx - int'(REQUESTERS);
      if (!found && cand[idx]) begin
        winner = IW'(idx);
        found  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/cache_port_arbiter.sv
// Round-robin sharing of one next-level cache port among REQUESTERS upstream caches.
// Define CACHE_ARB_WB_PRIORITY_EN to let pending writebacks win over reads.
module cache_port_arbiter
  import cachepkg::*;
#(
  parameter int unsigned REQUESTERS = 2,
  parameter int unsigned ADDRBITS   = 32,
  parameter int unsigned WORDBITS   = 32
) (
  input  logic                                 clock,
  input  logic                                 reset,
  input  logic [REQUESTERS-1:0]                up_request,
  input  logic [REQUESTERS-1:0]                up_write,
  input  logic [REQUESTERS-1:0][ADDRBITS-1:0]  up_addr,
  input  logic [REQUESTERS-1:0][WORDBITS-1:0]  up_wdata,
  output logic [REQUESTERS-1:0]                up_valid,
  output logic [WORDBITS-1:0]                  up_rdata,
  output logic                                 nl_request,
  output logic                                 nl_write,
  output logic [ADDRBITS-1:0]                  nl_addr,
  output logic [WORDBITS-1:0]                  nl_wdata,
  input  logic                                 nl_valid,
  input  logic [WORDBITS-1:0]                  nl_rdata,
  output logic                                 busy,
  output arb_state_t                           dbg_state
);

  localparam int unsigned IW = idx_bits(REQUESTERS);

  // Handshake: a requester holds up_request (and its command) until it sees a
  // one-cycle up_valid; downstream gets a one-cycle nl_request with the command
  // held stable until the one-cycle nl_valid that completes it.

  arb_state_t              state_q, state_d;
  logic [IW-1:0]           ptr_q, ptr_d;
  logic [IW-1:0]           g_q, g_d;
  logic                    write_q, write_d;
  logic [ADDRBITS-1:0]     addr_q, addr_d;
  logic [WORDBITS-1:0]     wdata_q, wdata_d;
  logic [REQUESTERS-1:0]   up_valid_q, up_valid_d;
  logic [WORDBITS-1:0]     up_rdata_q, up_rdata_d;
  logic                    nl_request_q, nl_request_d;
  logic                    busy_q, busy_d;

  logic [REQUESTERS-1:0]   prio_mask;
  logic [IW-1:0]           pick_idx;
  logic                    pick_any;

`ifdef CACHE_ARB_WB_PRIORITY_EN
  assign prio_mask = up_write;
`else
  assign prio_mask = '0;
`endif

  rr_picker #(
    .REQUESTERS (REQUESTERS)
  ) u_picker (
    .req       (up_request),
    .ptr       (ptr_q),
    .prio_mask (prio_mask),
    .winner    (pick_idx),
    .any_valid (pick_any)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      ptr_q        <= '0;
      g_q          <= '0;
      write_q      <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      up_valid_q   <= '0;
      up_rdata_q   <= '0;
      nl_request_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      g_q          <= g_d;
      write_q      <= write_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      up_valid_q   <= up_valid_d;
      up_rdata_q   <= up_rdata_d;
      nl_request_q <= nl_request_d;
      busy_q       <= busy_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (pick_any) state_d = ISSUE;
      ISSUE:   state_d = WAIT;
      WAIT:    if (nl_valid) state_d = RESPOND;
      RESPOND: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Every output is computed one cycle ahead so it leaves the block from a flop.
  always_comb begin
    ptr_d        = ptr_q;
    g_d          = g_q;
    write_d      = write_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    up_valid_d   = '0;
    up_rdata_d   = up_rdata_q;
    nl_request_d = 1'b0;

    if (state_q == IDLE && pick_any) begin
      g_d          = pick_idx;
      write_d      = up_write[pick_idx];
      addr_d       = up_addr[pick_idx];
      wdata_d      = up_wdata[pick_idx];
      nl_request_d = 1'b1;
    end

    if (state_q == WAIT && nl_valid) begin
      up_valid_d[g_q] = 1'b1;
      up_rdata_d      = write_q ? '0 : nl_rdata;
    end

    if (state_q == RESPOND) begin
      ptr_d = (g_q == IW'(REQUESTERS - 1)) ? '0 : g_q + 1'b1;
    end

    busy_d = (state_d != IDLE);
  end

  assign up_valid   = up_valid_q;
  assign up_rdata   = up_rdata_q;
  assign nl_request = nl_request_q;
  assign nl_write   = write_q;
  assign nl_addr    = addr_q;
  assign nl_wdata   = wdata_q;
  assign busy       = busy_q;
  assign dbg_state  = state_q;

endmodule
